// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer/status controller for a 16-entry UART FIFO; define FIFO_CTRL_STICKY_ERR_EN for sticky overflow/underflow
module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_C_WIDTH = 4,
  parameter int AF_LEVEL     = 14,
  parameter int AE_LEVEL     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic                    rd_req,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [FIFO_C_WIDTH-1:0] wr_addr,
  output logic [FIFO_C_WIDTH-1:0] rd_addr,
  output logic                    wr_en,
  output logic                    rd_ack,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [FIFO_C_WIDTH:0]   count,
  output logic                    overflow,
  output logic                    underflow
);
  logic [FIFO_C_WIDTH:0] r_wr_ptr, r_rd_ptr;
  logic                  w_ovf_ev, w_unf_ev;
  assign wr_addr      = r_wr_ptr[FIFO_C_WIDTH-1:0];
  assign rd_addr      = r_rd_ptr[FIFO_C_WIDTH-1:0];
  assign count        = r_wr_ptr - r_rd_ptr;
  assign empty        = r_wr_ptr == r_rd_ptr;
  assign full         = (wr_addr == rd_addr) && (r_wr_ptr[FIFO_C_WIDTH] != r_rd_ptr[FIFO_C_WIDTH]);
  assign almost_full  = count >= (FIFO_C_WIDTH+1)'(AF_LEVEL);
  assign almost_empty = count <= (FIFO_C_WIDTH+1)'(AE_LEVEL);
  assign wr_en        = wr_req & ~full & ~flush;
  assign rd_ack       = rd_req & ~empty & ~flush;
  assign w_ovf_ev     = wr_req & full & ~flush;
  assign w_unf_ev     = rd_req & empty & ~flush;
  // advance pointers on accepted ops; flush returns both to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (FIFO_C_WIDTH+1)'(wr_en);
      r_rd_ptr <= r_rd_ptr + (FIFO_C_WIDTH+1)'(rd_ack);
    end
  end
`ifdef FIFO_CTRL_STICKY_ERR_EN
  // sticky error flags: a new event wins over a coincident clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_ovf_ev | (overflow & ~err_clr);
      underflow <= w_unf_ev | (underflow & ~err_clr);
    end
  end
`else
  logic w_unused;
  assign w_unused = err_clr;
  // one-cycle registered pulse per rejected request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= w_ovf_ev;
      underflow <= w_unf_ev;
    end
  end
`endif
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed plus randomized check of uart_fifo_ctrl against a queue-based reference model
module tb_uart_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst, wr_req, rd_req, flush, err_clr;
  logic [3:0] wr_addr, rd_addr;
  logic       wr_en, rd_ack, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int         checks = 0;
  int         failures = 0;
  int         q[$];
  int         m_wa, m_ra;
  bit         m_ovf, m_unf;

  uart_fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .flush(flush), .err_clr(err_clr),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_en(wr_en), .rd_ack(rd_ack), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all(bit we, bit ra);
    chk("wr_en", 32'(wr_en), 32'(we));
    chk("rd_ack", 32'(rd_ack), 32'(ra));
    chk("count", 32'(count), q.size());
    chk("full", 32'(full), 32'(q.size() == 16));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("wr_addr", 32'(wr_addr), m_wa);
    chk("rd_addr", 32'(rd_addr), m_ra);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    q.delete();
    m_wa = 0;
    m_ra = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // async reset asserted away from the clock edge; outputs must respond at once
  task automatic do_reset();
    wr_req = 0; rd_req = 0; flush = 0; err_clr = 0;
    rst = 1;
    model_reset();
    #1;
    cmp_all(0, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  // one clock cycle: drive at edge+1, check at edge+4, update model after the edge
  task automatic step(bit w, bit r, bit f, bit c);
    bit fl, em, we, ra, ovf_ev, unf_ev;
    wr_req = w; rd_req = r; flush = f; err_clr = c;
    #3;
    fl = q.size() == 16;
    em = q.size() == 0;
    we = w && !fl && !f;
    ra = r && !em && !f;
    ovf_ev = w && fl && !f;
    unf_ev = r && em && !f;
    cmp_all(we, ra);
    if (ra) chk("head_order", 32'(rd_addr), q[0] % 16);
    @(posedge clk);
    if (f) begin
      q.delete();
      m_wa = 0;
      m_ra = 0;
    end else begin
      if (ra) begin
        void'(q.pop_front());
        m_ra = (m_ra + 1) % 16;
      end
      if (we) begin
        q.push_back(m_wa);
        m_wa = (m_wa + 1) % 16;
      end
    end
`ifdef FIFO_CTRL_STICKY_ERR_EN
    m_ovf = ovf_ev || (m_ovf && !c);
    m_unf = unf_ev || (m_unf && !c);
`else
    m_ovf = ovf_ev;
    m_unf = unf_ev;
`endif
    #1;
  endtask

  initial begin
    int bias;
    do_reset();
    repeat (17) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (17) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0);
    repeat (20) step(1, 1, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (15) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    do_reset();
    repeat (5) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (16) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    repeat (6) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    do_reset();
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(15, 85);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
                $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Pointer and status controller for the UART's 16-entry FIFO storage array (synchronous write, combinational read). Drives the array's write address, read address and write enable from simple write/read request strobes, and reports occupancy, full/empty, threshold and error status. One instance sits beside each FIFO storage instance in the TX and RX paths.

## Interface
- FIFO_DEPTH, 16, number of entries; must equal 2**FIFO_C_WIDTH
- FIFO_C_WIDTH, 4, address width into the storage array
- AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_req  input  1  push request for this cycle
- rd_req  input  1  pop request for this cycle
- flush  input  1  synchronous clear of all contents
- err_clr  input  1  clears sticky error flags (ignored without macro)
- wr_addr  output  FIFO_C_WIDTH  write address to storage
- rd_addr  output  FIFO_C_WIDTH  read address to storage
- wr_en  output  1  write enable to storage
- rd_ack  output  1  pop accepted this cycle; storage data_out is the popped word
- full, empty  output  1  occupancy flags
- almost_full, almost_empty  output  1  threshold flags
- count  output  FIFO_C_WIDTH+1  entries held, 0..FIFO_DEPTH
- overflow, underflow  output  1  rejected-request indicators

## Operation
- Internal wr_ptr, rd_ptr: FIFO_C_WIDTH+1 bits each; MSB is the wrap bit. wr_addr/rd_addr = low FIFO_C_WIDTH bits.
- count = wr_ptr - rd_ptr (modulo 2**(FIFO_C_WIDTH+1)); empty = (wr_ptr == rd_ptr); full = (low bits equal, MSBs differ).
- full, empty, count, almost_* and addresses are functions of registered state only; no input-to-output path.
- wr_en = wr_req & ~full & ~flush; rd_ack = rd_req & ~empty & ~flush (combinational).
- On clk edge: wr_en increments wr_ptr; rd_ack increments rd_ptr; both may occur in one cycle (count unchanged).
- Write accepted iff not full, independent of simultaneous read. Read accepted iff not empty, independent of simultaneous write (no write-through on empty).
- Pointer wrap: low bits roll 15->0, wrap bit toggles.
- Rejected request: wr_req & full -> overflow event; rd_req & empty -> underflow event. Not raised during flush.
- flush: highest priority; next cycle wr_ptr = rd_ptr = 0; requests that cycle are dropped without error. Does not clear error flags.
- rst (any time, mid-transfer included): pointers 0, error flags 0 immediately.
- Reset output values: wr_addr 0, rd_addr 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0; wr_en/rd_ack 0 while requests low.

## Timing
- Write: data presented with wr_req in cycle N is stored at edge ending N; visible as rd data once it reaches rd_addr, earliest cycle N+1 (first-word fall-through).
- Read: when ~empty, storage data_out holds the head word in the same cycle; sample it in the cycle rd_ack is high.
- Status flags update one cycle after the accepted operation.
- Error pulse/set occurs at the edge ending the offending cycle (visible N+1).

## Configuration
- FIFO_CTRL_STICKY_ERR_EN defined: overflow/underflow are sticky registers, set on event, cleared only by err_clr or rst; event and err_clr in same cycle -> flag stays set.
- Not defined: overflow/underflow are single-cycle registered pulses (high in cycle N+1 for each rejected request in N); err_clr unused.

## Test plan
- Reset, then 16 writes of 0x00..0x0F -> count 16, full 1, almost_full 1 after 14th; 17th wr_req -> wr_en 0, overflow 1, storage unchanged.
- Drain 16 reads -> rd_ack each cycle, data 0x00..0x0F in order, empty 1 after last; extra rd_req -> rd_ack 0, underflow 1.
- Fill 8, then 20 cycles of simultaneous wr+rd -> count stays 8, pointers wrap past 15, data order preserved.
- Empty FIFO, wr_req+rd_req same cycle -> write accepted, read rejected, underflow 1, count 1. Full FIFO, both -> read accepted, write rejected, overflow 1, count 15.
- Fill 5, assert flush with wr_req -> next cycle count 0, empty 1, no overflow; assert rst mid-burst -> all outputs at reset values immediately.
- With FIFO_CTRL_STICKY_ERR_EN: overflow persists 10 cycles until err_clr; err_clr coincident with new overflow -> stays 1. Without: overflow high exactly one cycle.
